// File: rtl/time_keeper_set.sv
// Clock/calendar stage: 1 Hz prescaler, binary hh:mm:ss counters and a
// two-button (mode/inc) set mode with synchronized, debounced inputs.
module time_keeper_set #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [6:0] second,
    output logic [6:0] minute,
    output logic [6:0] hour,
    output logic [1:0] set_mode,
    output logic       sec_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t state, state_next;

    logic [1:0]    raw;
    logic [1:0]    sync1, sync2, db_level, db_prev, press;
    logic [DW-1:0] db_cnt [2];
    logic [PW-1:0] presc;
    logic          mode_press, inc_press, tick;

    // bit 0 = mode button, bit 1 = inc button
    assign raw = {btn_inc, btn_mode};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            db_prev  <= '0;
            press    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A mode press in the same cycle as an inc press swallows the inc.
    assign mode_press = press[0];
    assign inc_press  = press[1] & ~press[0];
    assign tick       = (state == RUN) && (presc == PW'(TICK_DIV - 1));
    assign set_mode   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (mode_press) begin
            case (state)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                default:  state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            second   <= '0;
            minute   <= '0;
            hour     <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            if (state == RUN && state_next == RUN) begin
                presc <= tick ? '0 : presc + 1'b1;
            end else begin
                presc <= '0;
            end

            if (tick) begin
                if (second == 7'd59) begin
                    second <= 7'd0;
                    if (minute == 7'd59) begin
                        minute <= 7'd0;
                        hour   <= (hour == 7'd23) ? 7'd0 : hour + 1'b1;
                    end else begin
                        minute <= minute + 1'b1;
                    end
                end else begin
                    second <= second + 1'b1;
                end
            end

            if (state == SET_HOUR && inc_press) begin
                hour <= (hour == 7'd23) ? 7'd0 : hour + 1'b1;
            end

            // Leaving SET_MIN restarts the second so the next tick is a full period away.
            if (state == SET_MIN) begin
                if (mode_press) begin
                    second <= 7'd0;
                end else if (inc_press) begin
                    minute <= (minute == 7'd59) ? 7'd0 : minute + 1'b1;
                end
            end
        end
    end

endmodule
